// File: rtl/exec_ctrl_pkg.sv
// Shared encodings and default widths for the run/step execution controller.
package exec_ctrl_pkg;

    localparam int DEF_PC_WIDTH  = 33;
    localparam int DEF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_FREE  = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_STEPN = 2'b10,
        MODE_BREAK = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEP_ONE = 3'd2,
        ST_STEP_N   = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

endpackage

// File: rtl/exec_ctrl_bp_match.sv
// Combinational breakpoint comparator: exact pc match, armed only in RUN with
// the break mode latched, or in STEP_N.
module bp_match
    import exec_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = DEF_PC_WIDTH
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_bp_addr,
    input  logic                i_bp_enable,
    input  mode_t               i_mode,
    input  state_t              i_state,
    output logic                o_match
);

    logic w_armed;

    assign w_armed = (i_state == ST_STEP_N) ||
                     ((i_state == ST_RUN) && (i_mode == MODE_BREAK));
    assign o_match = i_bp_enable && w_armed && (i_pc == i_bp_addr);

endmodule

// File: rtl/exec_ctrl.sv
// Run/step sequencer producing the one-cycle pipeline advance enable, with
// free-run, single-step, step-N and run-to-breakpoint modes.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int PC_WIDTH  = DEF_PC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [1:0]           i_mode,
    input  logic                 i_step_pulse,
    input  logic                 i_tick,
    input  logic [CNT_WIDTH-1:0] i_step_count,
    input  logic                 i_bp_enable,
    input  logic [PC_WIDTH-1:0]  i_bp_addr,
    input  logic [PC_WIDTH-1:0]  i_pc,
    input  logic                 i_halt_req,
    output logic                 o_advance,
    output logic                 o_running,
    output logic                 o_halted,
    output logic                 o_bp_hit,
    output logic [CNT_WIDTH-1:0] o_steps_left,
    output logic [CNT_WIDTH-1:0] o_cycle_count
);

    state_t               r_state;
    mode_t                r_mode;
    logic                 r_advance;
    logic                 r_running;
    logic                 r_halted;
    logic                 r_bp_hit;
    logic [CNT_WIDTH-1:0] r_steps_left;
    logic [CNT_WIDTH-1:0] r_cycle_count;
    logic                 w_bp_match;

    bp_match #(
        .PC_WIDTH (PC_WIDTH)
    ) u_bp_match (
        .i_pc        (i_pc),
        .i_bp_addr   (i_bp_addr),
        .i_bp_enable (i_bp_enable),
        .i_mode      (r_mode),
        .i_state     (r_state),
        .o_match     (w_bp_match)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // branch below reads the values from the start of the cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_FREE;
            r_advance     <= 1'b0;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_bp_hit      <= 1'b0;
            r_steps_left  <= '0;
            r_cycle_count <= '0;
        end else begin
            r_advance <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_halt_req) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (i_step_pulse) begin
                        r_mode <= mode_t'(i_mode);
                        case (mode_t'(i_mode))
                            MODE_FREE, MODE_BREAK: begin
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
                            end
                            MODE_STEP: r_state <= ST_STEP_ONE;
                            default: begin
                                // A zero step count is a no-op start.
                                if (i_step_count != '0) begin
                                    r_state      <= ST_STEP_N;
                                    r_running    <= 1'b1;
                                    r_steps_left <= i_step_count;
                                end
                            end
                        endcase
                    end
                end

                ST_STEP_ONE: begin
                    r_state <= (i_halt_req) ? ST_HALT : ST_IDLE;
                    if (i_halt_req) begin
                        r_halted <= 1'b1;
                    end else begin
                        r_advance     <= 1'b1;
                        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
                    end
                end

                ST_RUN, ST_STEP_N: begin
                    if (i_halt_req) begin
                        r_state   <= ST_HALT;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end else if (w_bp_match && i_tick) begin
                        r_state   <= ST_HALT;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                        r_bp_hit  <= 1'b1;
                    end else if (i_step_pulse) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end else if (i_tick) begin
                        r_advance     <= 1'b1;
                        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
                        if (r_state == ST_STEP_N) begin
                            r_steps_left <= r_steps_left - CNT_WIDTH'(1);
                            if (r_steps_left == CNT_WIDTH'(1)) begin
                                r_state   <= ST_IDLE;
                                r_running <= 1'b0;
                            end
                        end
                    end
                end

                ST_HALT: begin
                    if (i_step_pulse && !i_halt_req) begin
                        r_state  <= ST_IDLE;
                        r_halted <= 1'b0;
                        r_bp_hit <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign o_advance     = r_advance;
    assign o_running     = r_running;
    assign o_halted      = r_halted;
    assign o_bp_hit      = r_bp_hit;
    assign o_steps_left  = r_steps_left;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed table, test-plan sequences and
// randomized cycles against a flag-based behavioural model.
module tb_exec_ctrl;

    localparam int PW = 33;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = '0;
    logic          step_pulse = 1'b0;
    logic          tick = 1'b0;
    logic [CW-1:0] step_count = '0;
    logic          bp_enable = 1'b0;
    logic [PW-1:0] bp_addr = '0;
    logic [PW-1:0] pc = '0;
    logic          halt_req = 1'b0;
    logic          advance, running, halted, bp_hit;
    logic [CW-1:0] steps_left, cycle_count;

    always #5 clock = ~clock;

    exec_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_mode        (mode),
        .i_step_pulse  (step_pulse),
        .i_tick        (tick),
        .i_step_count  (step_count),
        .i_bp_enable   (bp_enable),
        .i_bp_addr     (bp_addr),
        .i_pc          (pc),
        .i_halt_req    (halt_req),
        .o_advance     (advance),
        .o_running     (running),
        .o_halted      (halted),
        .o_bp_hit      (bp_hit),
        .o_steps_left  (steps_left),
        .o_cycle_count (cycle_count)
    );

    typedef struct packed {
        logic          adv;
        logic          run;
        logic          hlt;
        logic          bp;
        logic [CW-1:0] left;
        logic [CW-1:0] cc;
    } obs_t;

    typedef struct {
        logic          rst, step, tick, halt, bp_en;
        logic [1:0]    mode;
        logic [CW-1:0] cnt;
        logic [PW-1:0] pc, bp_addr;
    } in_t;

    typedef struct {
        in_t  in;
        obs_t exp;
    } vec_t;

    obs_t dut_obs;
    assign dut_obs = {advance, running, halted, bp_hit, steps_left, cycle_count};

    int n_vec = 0;
    int n_err = 0;

    // Model: what the sequencer is doing, as independent activity flags.
    bit m_adv, m_halted, m_bp, m_single, m_free, m_bounded;
    int m_left, m_cnt, m_mode;

    task automatic model_step(input in_t v);
        m_adv = 1'b0;
        if (v.rst) begin
            m_halted = 0; m_bp = 0; m_single = 0; m_free = 0; m_bounded = 0;
            m_left = 0; m_cnt = 0; m_mode = 0;
            return;
        end
        if (m_halted) begin
            if (v.step && !v.halt) begin
                m_halted = 0;
                m_bp = 0;
            end
        end else if (v.halt) begin
            m_halted = 1; m_single = 0; m_free = 0; m_bounded = 0;
        end else if (m_single) begin
            m_adv = 1;
            m_single = 0;
        end else if (m_free || m_bounded) begin
            if (v.tick && v.bp_en && (v.pc == v.bp_addr) && (m_bounded || m_mode == 3)) begin
                m_halted = 1; m_bp = 1; m_free = 0; m_bounded = 0;
            end else if (v.step) begin
                m_free = 0; m_bounded = 0;
            end else if (v.tick) begin
                m_adv = 1;
                if (m_bounded) begin
                    m_left--;
                    if (m_left == 0) m_bounded = 0;
                end
            end
        end else if (v.step) begin
            m_mode = int'(v.mode);
            if (m_mode == 0 || m_mode == 3) m_free = 1;
            else if (m_mode == 1) m_single = 1;
            else if (v.cnt != 0) begin
                m_bounded = 1;
                m_left = int'(v.cnt);
            end
        end
        if (m_adv) m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.adv  = m_adv;
        o.run  = m_free || m_bounded;
        o.hlt  = m_halted;
        o.bp   = m_bp;
        o.left = CW'(m_left);
        o.cc   = CW'(m_cnt);
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got adv=%0b run=%0b halt=%0b bp=%0b left=%0d cc=%0d, want adv=%0b run=%0b halt=%0b bp=%0b left=%0d cc=%0d",
                     name, act.adv, act.run, act.hlt, act.bp, act.left, act.cc,
                     exp.adv, exp.run, exp.hlt, exp.bp, exp.left, exp.cc);
        end
    endtask

    task automatic check_v(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic in_t idle_in();
        in_t v;
        v.rst = 0; v.step = 0; v.tick = 0; v.halt = 0; v.bp_en = 0;
        v.mode = 2'b00; v.cnt = '0; v.pc = '0; v.bp_addr = '0;
        return v;
    endfunction

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic apply(input in_t v, input bit chk, input string name);
        reset = v.rst; step_pulse = v.step; tick = v.tick; halt_req = v.halt;
        bp_enable = v.bp_en; mode = v.mode; step_count = v.cnt;
        pc = v.pc; bp_addr = v.bp_addr;
        model_step(v);
        @(posedge clock);
        #1;
        if (chk) check(name, dut_obs, model_obs());
    endtask

    function automatic vec_t mk(input logic rst, step, tk, hlt, input logic [1:0] md,
                                input int cnt, input logic adv, run, hl, bp,
                                input int left, input int cc);
        vec_t r;
        r.in = idle_in();
        r.in.rst = rst; r.in.step = step; r.in.tick = tk; r.in.halt = hlt;
        r.in.mode = md; r.in.cnt = CW'(cnt);
        r.exp.adv = adv; r.exp.run = run; r.exp.hlt = hl; r.exp.bp = bp;
        r.exp.left = CW'(left); r.exp.cc = CW'(cc);
        return r;
    endfunction

    vec_t tbl[19];

    initial begin
        in_t v;
        int  n_adv;

        //            rst stp tck hlt mode cnt   adv run hlt bp left cc
        tbl[0]  = mk(1, 0, 0, 0, 2'd0, 0,   0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 2'd2, 3,   0, 1, 0, 0, 3, 0);
        tbl[2]  = mk(0, 0, 1, 0, 2'd0, 0,   1, 1, 0, 0, 2, 1);
        tbl[3]  = mk(0, 0, 0, 0, 2'd0, 0,   0, 1, 0, 0, 2, 1);
        tbl[4]  = mk(0, 0, 1, 0, 2'd0, 0,   1, 1, 0, 0, 1, 2);
        tbl[5]  = mk(0, 0, 1, 0, 2'd0, 0,   1, 0, 0, 0, 0, 3);
        tbl[6]  = mk(0, 0, 1, 0, 2'd0, 0,   0, 0, 0, 0, 0, 3);
        tbl[7]  = mk(0, 0, 1, 0, 2'd0, 0,   0, 0, 0, 0, 0, 3);
        tbl[8]  = mk(0, 1, 0, 0, 2'd2, 0,   0, 0, 0, 0, 0, 3);
        tbl[9]  = mk(0, 0, 1, 0, 2'd0, 0,   0, 0, 0, 0, 0, 3);
        tbl[10] = mk(0, 1, 0, 0, 2'd1, 0,   0, 0, 0, 0, 0, 3);
        tbl[11] = mk(0, 0, 0, 0, 2'd0, 0,   1, 0, 0, 0, 0, 4);
        tbl[12] = mk(0, 0, 0, 0, 2'd0, 0,   0, 0, 0, 0, 0, 4);
        tbl[13] = mk(0, 0, 0, 1, 2'd0, 0,   0, 0, 1, 0, 0, 4);
        tbl[14] = mk(0, 1, 0, 1, 2'd0, 0,   0, 0, 1, 0, 0, 4);
        tbl[15] = mk(0, 1, 0, 0, 2'd0, 0,   0, 0, 0, 0, 0, 4);
        tbl[16] = mk(0, 1, 0, 0, 2'd0, 0,   0, 1, 0, 0, 0, 4);
        tbl[17] = mk(0, 0, 1, 1, 2'd0, 0,   0, 0, 1, 0, 0, 4);
        tbl[18] = mk(0, 1, 0, 0, 2'd0, 0,   0, 0, 0, 0, 0, 4);

        foreach (tbl[i]) begin
            apply(tbl[i].in, 1'b0, "");
            check($sformatf("table[%0d]", i), dut_obs, tbl[i].exp);
        end

        // Free-run: ticks at 10, 20, 30 give advances at 11, 21, 31 only.
        v = idle_in(); v.rst = 1;
        apply(v, 1'b1, "t1_reset");
        n_adv = 0;
        for (int c = 0; c <= 35; c++) begin
            v = idle_in();
            v.step = (c == 0);
            v.tick = (c == 10 || c == 20 || c == 30);
            apply(v, 1'b0, "");
            n_adv += int'(advance);
            if (c == 10 || c == 20 || c == 30 || c == 11 || c == 0)
                check_v($sformatf("t1_adv_c%0d", c + 1), int'(advance), int'(c == 10 || c == 20 || c == 30));
        end
        check_v("t1_adv_total", n_adv, 3);
        check_v("t1_cycle_count", int'(cycle_count), 3);
        check_v("t1_running", int'(running), 1);
        v = idle_in(); v.step = 1;
        apply(v, 1'b0, "");
        check_v("t1_paused", int'(running), 0);

        // Run-to-breakpoint at 0x10.
        v = idle_in(); v.rst = 1;
        apply(v, 1'b1, "t4_reset");
        v = idle_in(); v.step = 1; v.mode = 2'b11; v.bp_en = 1; v.bp_addr = PW'(16);
        apply(v, 1'b1, "t4_start");
        for (int k = 0; k <= 4; k++) begin
            v = idle_in(); v.bp_en = 1; v.bp_addr = PW'(16); v.pc = PW'(4 * k); v.tick = 1;
            apply(v, 1'b1, $sformatf("t4_tick_pc%0d", 4 * k));
            check_v($sformatf("t4_adv_pc%0d", 4 * k), int'(advance), int'(k < 4));
            v.tick = 0;
            apply(v, 1'b1, "t4_gap");
        end
        check_v("t4_halted", int'(halted), 1);
        check_v("t4_bp_hit", int'(bp_hit), 1);
        check_v("t4_count", int'(cycle_count), 4);
        v = idle_in(); v.step = 1;
        apply(v, 1'b1, "t4_resume");
        check_v("t4_bp_cleared", int'(bp_hit), 0);

        // cycle_count wrap: 0xFFFE advances, then two more.
        v = idle_in(); v.rst = 1;
        apply(v, 1'b1, "t6_reset");
        v = idle_in(); v.step = 1;
        apply(v, 1'b1, "t6_start");
        v = idle_in(); v.tick = 1;
        for (int k = 0; k < 16'hFFFE; k++) apply(v, 1'b0, "");
        check_v("t6_near_wrap", int'(cycle_count), 16'hFFFE);
        apply(v, 1'b0, "");
        check_v("t6_at_max", int'(cycle_count), 16'hFFFF);
        apply(v, 1'b1, "t6_wrap_obs");
        check_v("t6_wrapped", int'(cycle_count), 0);

        // Reset in the middle of STEP_N.
        v = idle_in(); v.step = 1;
        apply(v, 1'b1, "t6_pause");
        v = idle_in(); v.step = 1; v.mode = 2'b10; v.cnt = CW'(5);
        apply(v, 1'b1, "t6_stepn");
        v = idle_in(); v.tick = 1;
        apply(v, 1'b1, "t6_stepn_tick");
        v = idle_in(); v.rst = 1; v.tick = 1;
        apply(v, 1'b0, "");
        check("t6_mid_reset", dut_obs, obs_t'(0));
        v = idle_in(); v.tick = 1;
        apply(v, 1'b0, "");
        check_v("t6_post_reset_adv", int'(advance), 0);

        // Randomized cycles against the model.
        v = idle_in(); v.rst = 1;
        apply(v, 1'b1, "rand_reset");
        for (int i = 0; i < 3000; i++) begin
            v = idle_in();
            v.rst   = ($urandom % 200) == 0;
            v.step  = ($urandom % 12) == 0;
            v.tick  = ($urandom % 3) == 0;
            v.halt  = ($urandom % 25) == 0;
            v.mode  = 2'($urandom);
            v.cnt   = CW'($urandom_range(0, 5));
            v.bp_en = $urandom % 2;
            v.bp_addr = PW'($urandom_range(0, 7) * 4);
            v.pc      = PW'($urandom_range(0, 7) * 4);
            v.pc[PW-1]      = ($urandom % 8) == 0;
            v.bp_addr[PW-1] = ($urandom % 8) == 0;
            apply(v, 1'b1, $sformatf("rand[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
